// File: rtl/tt_pin_cmd_responder_if.sv
// Pin-level bundle between the host-facing pads and the command responder.
// The host drives enable, data and strobe/abort; the responder returns data and status.
interface tt_pin_cmd_responder_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_pin_cmd_responder.sv
// Byte-command responder: strobe-framed reads/writes of a small config register file.
//   state | meaning
//   IDLE  | waiting for a command byte
//   WDATA | accepting write data bytes, rem left to go
//   RDATA | presenting read data, host acks each byte with a strobe
module tt_pin_cmd_responder #(
    parameter int NREGS  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    tt_pin_cmd_responder_if.slave pins,
    output logic [NREGS*8-1:0]    cfg_out,
    input  logic [7:0]            stat_in
);
    if (NREGS != (1 << ADDR_W) || ADDR_W > 4) begin : g_param_check
        $error("NREGS must equal 2**ADDR_W with ADDR_W <= 4");
    end

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NREGS - 1);

    typedef enum logic [1:0] {IDLE, WDATA, RDATA} state_t;

    state_t              state, state_nxt;
    logic [7:0]          regs [NREGS];
    logic [ADDR_W-1:0]   addr_q;
    logic [2:0]          rem_q;
    logic                inc_q;
    logic                err_q;
    logic                rvalid_q;
    logic                ack_tgl_q;
    logic                stb_q;
    logic [7:0]          uo_q;
    logic                busy;
    logic [ADDR_W-1:0]   rd_addr;
    logic [7:0]          rd_byte;

    wire stb    = pins.uio_in[0];
    wire abort  = pins.uio_in[1];
    wire stb_edge = stb & ~stb_q & pins.ena & ~abort;

    logic unused_bits;
    assign unused_bits = ^{pins.uio_in[7:2], pins.ui_in};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = IDLE;
        end else if (stb_edge) begin
            case (state)
                IDLE:    state_nxt = pins.ui_in[7] ? RDATA : WDATA;
                WDATA:   if (rem_q == 3'd1) state_nxt = IDLE;
                RDATA:   if (rem_q == 3'd0) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // In IDLE the read address comes straight from the command byte; later loads step from addr_q.
    always_comb begin
        busy = (state != IDLE);
        if (state == IDLE)  rd_addr = pins.ui_in[ADDR_W-1:0];
        else if (inc_q)     rd_addr = addr_q + ADDR_W'(1);
        else                rd_addr = addr_q;
        rd_byte = (rd_addr == LAST_ADDR) ? stat_in : regs[rd_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= 8'h00;
            addr_q    <= '0;
            rem_q     <= 3'd0;
            inc_q     <= 1'b0;
            err_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            ack_tgl_q <= 1'b0;
            stb_q     <= 1'b0;
            uo_q      <= 8'h00;
        end else begin
            stb_q <= stb;
            if (abort) begin
                rvalid_q <= 1'b0;
                uo_q     <= 8'h00;
                err_q    <= 1'b0;
            end else if (stb_edge) begin
                ack_tgl_q <= ~ack_tgl_q;
                case (state)
                    IDLE: begin
                        addr_q <= pins.ui_in[ADDR_W-1:0];
                        inc_q  <= pins.ui_in[6];
                        err_q  <= 1'b0;
                        if (pins.ui_in[7]) begin
                            uo_q     <= rd_byte;
                            rvalid_q <= 1'b1;
                            rem_q    <= {1'b0, pins.ui_in[5:4]};
                        end else begin
                            rem_q <= {1'b0, pins.ui_in[5:4]} + 3'd1;
                        end
                    end
                    WDATA: begin
                        // The top address is the read-only status slot.
                        if (addr_q != LAST_ADDR) regs[addr_q] <= pins.ui_in;
                        else                     err_q <= 1'b1;
                        if (inc_q) addr_q <= addr_q + ADDR_W'(1);
                        rem_q <= rem_q - 3'd1;
                    end
                    RDATA: begin
                        if (rem_q == 3'd0) begin
                            rvalid_q <= 1'b0;
                            uo_q     <= 8'h00;
                        end else begin
                            addr_q <= rd_addr;
                            uo_q   <= rd_byte;
                            rem_q  <= rem_q - 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_cfg
        assign cfg_out[8*g +: 8] = regs[g];
    end

    assign pins.uo_out  = uo_q;
    assign pins.uio_out = {ack_tgl_q, err_q, busy, rvalid_q, 4'h0};
    assign pins.uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_pin_cmd_responder.sv
// Scoreboard bench: each strobe pushes the expected pin snapshot, popped when ack_tgl flips.
module tb_tt_pin_cmd_responder;
    logic         clk;
    logic         rst_n;
    logic         ena;
    logic [7:0]   ui_in;
    logic         stb;
    logic         abort;
    logic [7:0]   stat_in;
    logic [127:0] cfg_out;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string      tag;
        logic [11:0] val;
    } sb_t;

    sb_t  exp_q [$];
    logic exp_ack;
    logic ack_prev;

    tt_pin_cmd_responder_if bus ();

    assign bus.ena    = ena;
    assign bus.ui_in  = ui_in;
    assign bus.uio_in = {6'b0, abort, stb};

    tt_pin_cmd_responder #(.NREGS(16), .ADDR_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .pins    (bus.slave),
        .cfg_out (cfg_out),
        .stat_in (stat_in)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            ack_prev = 1'b0;
        end else begin
            if (bus.uio_out[7] !== ack_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_ack", 1, 0);
                end else begin
                    sb_t e;
                    e = exp_q.pop_front();
                    check(e.tag, {bus.uio_out[7:4], bus.uo_out}, e.val);
                end
            end
            ack_prev = bus.uio_out[7];
        end
    end

    function automatic logic [7:0] reg_at(input int i);
        return cfg_out[8*i +: 8];
    endfunction

    // Expected flags are {err, busy, rvalid}; ack is tracked by the bench.
    task automatic strobe(input string tag, input logic [7:0] d, input logic [2:0] flags,
                          input logic [7:0] e_uo);
        exp_ack = ~exp_ack;
        exp_q.push_back('{tag: tag, val: {exp_ack, flags, e_uo}});
        @(negedge clk);
        ui_in = d;
        stb   = 1'b1;
        @(negedge clk);
        stb = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; stb = 1'b0; abort = 1'b0;
        stat_in = 8'h5A; exp_ack = 1'b0; ack_prev = 1'b0;
        idle_cycles(3);
        rst_n = 1'b1;
        idle_cycles(1);

        check("rst_uo_out", bus.uo_out, 8'h00);
        check("rst_uio_out", bus.uio_out, 8'h00);
        check("rst_uio_oe", bus.uio_oe, 8'hF0);
        check("rst_cfg_out", cfg_out, 128'h0);

        // single write to reg 3
        strobe("w1_cmd",  8'h03, 3'b010, 8'h00);
        strobe("w1_data", 8'hA5, 3'b000, 8'h00);
        check("w1_reg3", reg_at(3), 8'hA5);

        // burst write crossing the status slot and wrapping
        strobe("bw_cmd", 8'h7E, 3'b010, 8'h00);
        strobe("bw_d0",  8'h11, 3'b010, 8'h00);
        strobe("bw_d1",  8'h22, 3'b110, 8'h00);
        strobe("bw_d2",  8'h33, 3'b110, 8'h00);
        strobe("bw_d3",  8'h44, 3'b100, 8'h00);
        check("bw_reg14", reg_at(14), 8'h11);
        check("bw_reg15", reg_at(15), 8'h00);
        check("bw_reg0",  reg_at(0),  8'h33);
        check("bw_reg1",  reg_at(1),  8'h44);
        check("bw_reg3",  reg_at(3),  8'hA5);

        strobe("r0_cmd", 8'h80, 3'b011, 8'h33);
        strobe("r0_end", 8'h00, 3'b000, 8'h00);

        // incrementing read from the status slot wrapping to reg 0
        strobe("ri_cmd", 8'hDF, 3'b011, 8'h5A);
        strobe("ri_b1",  8'hFF, 3'b011, 8'h33);
        strobe("ri_end", 8'hFF, 3'b000, 8'h00);

        // non-incrementing read re-samples status
        strobe("rs_cmd", 8'h9F, 3'b011, 8'h5A);
        stat_in = 8'hC3;
        strobe("rs_b1",  8'h00, 3'b011, 8'hC3);
        strobe("rs_end", 8'h00, 3'b000, 8'h00);

        // abort after one of three write bytes (first byte hits status slot, sets err)
        strobe("ab_cmd", 8'h6F, 3'b010, 8'h00);
        strobe("ab_d0",  8'h77, 3'b110, 8'h00);
        @(negedge clk);
        abort = 1'b1; stb = 1'b1; ui_in = 8'h99;
        idle_cycles(2);
        abort = 1'b0; stb = 1'b0;
        idle_cycles(1);
        check("ab_flags", bus.uio_out[6:4], 3'b000);
        check("ab_reg0", reg_at(0), 8'h33);
        check("ab_reg1", reg_at(1), 8'h44);
        check("ab_reg15", reg_at(15), 8'h00);
        strobe("ab_next_cmd", 8'h81, 3'b011, 8'h44);
        strobe("ab_next_end", 8'h00, 3'b000, 8'h00);

        // strobes ignored while deselected, and no edge on ena rise with stb high
        ena = 1'b0;
        repeat (2) begin
            ui_in = 8'h80; stb = 1'b1; idle_cycles(1);
            stb = 1'b0; idle_cycles(1);
        end
        stb = 1'b1; idle_cycles(2);
        ena = 1'b1; idle_cycles(2);
        stb = 1'b0; idle_cycles(1);
        check("ena_flags", bus.uio_out, {exp_ack, 7'b0});
        check("ena_uo", bus.uo_out, 8'h00);

        // ena low mid-write freezes the transaction
        strobe("fz_cmd", 8'h05, 3'b010, 8'h00);
        ena = 1'b0;
        ui_in = 8'hEE; stb = 1'b1; idle_cycles(1); stb = 1'b0; idle_cycles(1);
        check("fz_busy", bus.uio_out[5], 1'b1);
        check("fz_reg5", reg_at(5), 8'h00);
        ena = 1'b1;
        strobe("fz_data", 8'h5C, 3'b000, 8'h00);
        check("fz_reg5_after", reg_at(5), 8'h5C);

        // reset in the middle of a read
        strobe("rr_cmd", 8'hD0, 3'b011, 8'h33);
        #2 rst_n = 1'b0;
        #1;
        check("rr_uo_out", bus.uo_out, 8'h00);
        check("rr_uio_out", bus.uio_out, 8'h00);
        check("rr_cfg_out", cfg_out, 128'h0);
        exp_ack = 1'b0;
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
        check("rr_still_idle", bus.uio_out, 8'h00);
        check("sb_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
